// File: rtl/btn_pkg.sv
// Shared types and elaboration-time helpers for the button conditioner.
// Hold-FSM encodings plus counter-width helpers used by every channel.
package btn_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PRESSED = 2'd1,
        ST_HELD    = 2'd2
    } hold_state_e;

    // Bits needed to hold 0..count-1; never less than one bit.
    function automatic int clog2_w(input int count);
        int w;
        w = 1;
        while ((1 << w) < count) begin
            w = w + 1;
        end
        return w;
    endfunction

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/btn_channel.sv
// One button channel: two-flop synchroniser, stability-window debouncer,
// and a hold FSM producing long-press and auto-repeat pulses.
//
// state      | meaning
// -----------+-------------------------------------------------------------
// ST_IDLE    | debounced level low, hold counter parked at 0
// ST_PRESSED | press seen, counting towards the long-press pulse
// ST_HELD    | long press issued, counting repeat periods
module btn_channel
    import btn_pkg::*;
#(
    parameter int DEBOUNCE_CYC = 131072,
    parameter int LONG_CYC     = 100000000,
    parameter int REPEAT_CYC   = 20000000,
    parameter int REPEAT_EN    = 1
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_btn,
    output logic o_level,
    output logic o_press,
    output logic o_release,
    output logic o_long,
    output logic o_repeat
);

    localparam int DB_W   = clog2_w(DEBOUNCE_CYC);
    localparam int HOLD_W = clog2_w(max_int(LONG_CYC, REPEAT_CYC));

    localparam logic [DB_W-1:0]   DB_TC     = DB_W'(DEBOUNCE_CYC - 1);
    localparam logic [HOLD_W-1:0] LONG_TC   = HOLD_W'(LONG_CYC - 1);
    localparam logic [HOLD_W-1:0] REPEAT_TC = HOLD_W'(REPEAT_CYC - 1);
    localparam logic              REP_ON    = (REPEAT_EN != 0);

    logic              sync0;
    logic              sync1;
    logic [DB_W-1:0]   db_cnt;
    logic [DB_W-1:0]   db_cnt_nxt;
    logic              db_mismatch;
    logic              db_done;
    logic              rise_ev;
    logic              fall_ev;

    hold_state_e       state;
    hold_state_e       state_nxt;
    logic [HOLD_W-1:0] hold_cnt;
    logic [HOLD_W-1:0] hold_cnt_nxt;
    logic              long_nxt;
    logic              repeat_nxt;

    // Any cycle where the synchronised input agrees with o_level restarts the window.
    always_comb begin
        db_mismatch = (sync1 != o_level);
        db_done     = db_mismatch && (db_cnt == DB_TC);
        rise_ev     = db_done && sync1;
        fall_ev     = db_done && !sync1;
        db_cnt_nxt  = '0;
        if (db_mismatch && !db_done) begin
            db_cnt_nxt = db_cnt + DB_W'(1);
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            sync0     <= 1'b0;
            sync1     <= 1'b0;
            db_cnt    <= '0;
            o_level   <= 1'b0;
            o_press   <= 1'b0;
            o_release <= 1'b0;
        end else begin
            sync0     <= i_btn;
            sync1     <= sync0;
            db_cnt    <= db_cnt_nxt;
            o_press   <= rise_ev;
            o_release <= fall_ev;
            if (db_done) begin
                o_level <= sync1;
            end
        end
    end

    // The FSM reacts to the same-edge debounce events, so a release always
    // wins over a long/repeat terminal count landing on that edge.
    always_comb begin
        state_nxt    = state;
        hold_cnt_nxt = hold_cnt;
        long_nxt     = 1'b0;
        repeat_nxt   = 1'b0;
        case (state)
            ST_IDLE: begin
                hold_cnt_nxt = '0;
                if (rise_ev) begin
                    state_nxt = ST_PRESSED;
                end
            end
            ST_PRESSED: begin
                if (fall_ev) begin
                    state_nxt    = ST_IDLE;
                    hold_cnt_nxt = '0;
                end else if (hold_cnt == LONG_TC) begin
                    state_nxt    = ST_HELD;
                    hold_cnt_nxt = '0;
                    long_nxt     = 1'b1;
                end else begin
                    hold_cnt_nxt = hold_cnt + HOLD_W'(1);
                end
            end
            ST_HELD: begin
                if (fall_ev) begin
                    state_nxt    = ST_IDLE;
                    hold_cnt_nxt = '0;
                end else if (hold_cnt == REPEAT_TC) begin
                    hold_cnt_nxt = '0;
                    repeat_nxt   = REP_ON;
                end else begin
                    hold_cnt_nxt = hold_cnt + HOLD_W'(1);
                end
            end
            default: begin
                state_nxt    = ST_IDLE;
                hold_cnt_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state    <= ST_IDLE;
            hold_cnt <= '0;
            o_long   <= 1'b0;
            o_repeat <= 1'b0;
        end else begin
            state    <= state_nxt;
            hold_cnt <= hold_cnt_nxt;
            o_long   <= long_nxt;
            o_repeat <= repeat_nxt;
        end
    end

endmodule

// File: rtl/btn_conditioner.sv
// Multi-channel button front end: N_CH independent btn_channel instances
// whose per-channel outputs are packed into bit vectors.
module btn_conditioner
    import btn_pkg::*;
#(
    parameter int N_CH         = 5,
    parameter int DEBOUNCE_CYC = 131072,
    parameter int LONG_CYC     = 100000000,
    parameter int REPEAT_CYC   = 20000000,
    parameter int REPEAT_EN    = 1
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic [N_CH-1:0] i_btn,
    output logic [N_CH-1:0] o_level,
    output logic [N_CH-1:0] o_press,
    output logic [N_CH-1:0] o_release,
    output logic [N_CH-1:0] o_long,
    output logic [N_CH-1:0] o_repeat
);

    for (genvar ch = 0; ch < N_CH; ch++) begin : g_ch
        btn_channel #(
            .DEBOUNCE_CYC (DEBOUNCE_CYC),
            .LONG_CYC     (LONG_CYC),
            .REPEAT_CYC   (REPEAT_CYC),
            .REPEAT_EN    (REPEAT_EN)
        ) u_channel (
            .i_clk     (i_clk),
            .i_rst     (i_rst),
            .i_btn     (i_btn[ch]),
            .o_level   (o_level[ch]),
            .o_press   (o_press[ch]),
            .o_release (o_release[ch]),
            .o_long    (o_long[ch]),
            .o_repeat  (o_repeat[ch])
        );
    end

endmodule

// File: tb/tb_btn_conditioner.sv
// Scoreboard bench: stimulus queues expected pulses (cycle, channel, kind),
// a negedge monitor matches every DUT pulse and flags missing ones.
module tb_btn_conditioner;

    localparam int N_CH = 2;
    localparam int K_PRESS = 0, K_REL = 1, K_LONG = 2, K_REP = 3;

    typedef struct {
        int cyc;
        int ch;
        int kind;
    } exp_t;

    logic            clk;
    logic            rst;
    logic [N_CH-1:0] btn;
    logic [N_CH-1:0] o_level, o_press, o_release, o_long, o_repeat;
    logic [N_CH-1:0] nr_level, nr_press, nr_release, nr_long, nr_repeat;

    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];

    btn_conditioner #(
        .N_CH(N_CH), .DEBOUNCE_CYC(8), .LONG_CYC(32), .REPEAT_CYC(8), .REPEAT_EN(1)
    ) dut (
        .i_clk(clk), .i_rst(rst), .i_btn(btn),
        .o_level(o_level), .o_press(o_press), .o_release(o_release),
        .o_long(o_long), .o_repeat(o_repeat)
    );

    btn_conditioner #(
        .N_CH(N_CH), .DEBOUNCE_CYC(8), .LONG_CYC(32), .REPEAT_CYC(8), .REPEAT_EN(0)
    ) dut_norep (
        .i_clk(clk), .i_rst(rst), .i_btn(btn),
        .o_level(nr_level), .o_press(nr_press), .o_release(nr_release),
        .o_long(nr_long), .o_repeat(nr_repeat)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    function automatic string kname(input int k);
        case (k)
            K_PRESS: return "press";
            K_REL:   return "release";
            K_LONG:  return "long";
            default: return "repeat";
        endcase
    endfunction

    task automatic expect_ev(input int c, input int ch, input int k);
        exp_t e;
        e.cyc  = c;
        e.ch   = ch;
        e.kind = k;
        sb.push_back(e);
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    // Monitor: each observed pulse must match a queued expectation for this cycle.
    always @(negedge clk) begin
        if (!rst) begin
            for (int ch = 0; ch < N_CH; ch++) begin
                logic [3:0] p;
                p = {o_repeat[ch], o_long[ch], o_release[ch], o_press[ch]};
                for (int k = 0; k < 4; k++) begin
                    if (p[k]) begin
                        int idx;
                        idx = -1;
                        foreach (sb[i])
                            if (idx < 0 && sb[i].cyc == cyc && sb[i].ch == ch && sb[i].kind == k)
                                idx = i;
                        checks++;
                        if (idx < 0) begin
                            errors++;
                            $display("FAIL unexpected_%s ch%0d cycle %0d: got pulse, required none",
                                     kname(k), ch, cyc);
                        end else begin
                            sb.delete(idx);
                            checks++;
                            if (o_level[ch] !== (k != K_REL)) begin
                                errors++;
                                $display("FAIL level_at_%s ch%0d cycle %0d: got %b, required %b",
                                         kname(k), ch, cyc, o_level[ch], (k != K_REL));
                            end
                        end
                    end
                end
            end
            for (int i = sb.size() - 1; i >= 0; i--) begin
                if (sb[i].cyc <= cyc) begin
                    checks++;
                    errors++;
                    $display("FAIL missing_%s ch%0d: got no pulse at cycle %0d, required one",
                             kname(sb[i].kind), sb[i].ch, sb[i].cyc);
                    sb.delete(i);
                end
            end
            if ((|o_repeat) || (|nr_repeat)) begin
                checks++;
                if (nr_repeat !== '0) begin
                    errors++;
                    $display("FAIL norep_repeat cycle %0d: got %b, required 00", cyc, nr_repeat);
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout at cycle %0d, required completion", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        int p;
        int u;
        rst = 1'b1;
        btn = '0;
        repeat (3) @(negedge clk);
        chk("reset_outputs", {o_level, o_press, o_release, o_long, o_repeat}, 64'd0);
        chk("reset_outputs_norep", {nr_level, nr_press, nr_release, nr_long, nr_repeat}, 64'd0);
        rst = 1'b0;
        repeat (4) @(negedge clk);

        // Clean press, hold with long and repeats, then release.
        t = cyc;
        p = t + 10;
        btn[0] = 1'b1;
        expect_ev(p, 0, K_PRESS);
        expect_ev(p + 32, 0, K_LONG);
        for (int k = 0; k < 7; k++) expect_ev(p + 40 + 8 * k, 0, K_REP);
        wait_until(p - 1);
        chk("level_before_latency", 64'(o_level[0]), 64'd0);
        wait_until(p + 80);
        btn[0] = 1'b0;
        expect_ev(p + 90, 0, K_REL);
        chk("ch1_stays_low", 64'(o_level[1]), 64'd0);
        wait_until(p + 130);

        // Bounce: toggle every 3 cycles for 30 cycles, ending high.
        t = cyc;
        expect_ev(t + 40, 0, K_PRESS);
        for (int k = 0; k <= 10; k++) begin
            wait_until(t + 3 * k);
            btn[0] = ((k % 2) == 0);
        end
        wait_until(t + 35);
        chk("bounce_level_pending", 64'(o_level[0]), 64'd0);
        wait_until(t + 50);
        btn[0] = 1'b0;
        expect_ev(t + 60, 0, K_REL);
        wait_until(t + 100);

        // Release debounced exactly on the long-press terminal edge.
        t = cyc;
        btn[0] = 1'b1;
        expect_ev(t + 10, 0, K_PRESS);
        wait_until(t + 32);
        btn[0] = 1'b0;
        expect_ev(t + 42, 0, K_REL);
        wait_until(t + 90);

        // Release one cycle after the long press.
        t = cyc;
        btn[0] = 1'b1;
        expect_ev(t + 10, 0, K_PRESS);
        expect_ev(t + 42, 0, K_LONG);
        wait_until(t + 33);
        btn[0] = 1'b0;
        expect_ev(t + 43, 0, K_REL);
        wait_until(t + 90);

        // Two channels pressed 3 cycles apart.
        t = cyc;
        btn[0] = 1'b1;
        expect_ev(t + 10, 0, K_PRESS);
        expect_ev(t + 42, 0, K_LONG);
        expect_ev(t + 50, 0, K_REP);
        expect_ev(t + 58, 0, K_REP);
        expect_ev(t + 62, 0, K_REL);
        expect_ev(t + 13, 1, K_PRESS);
        expect_ev(t + 45, 1, K_LONG);
        expect_ev(t + 53, 1, K_REP);
        expect_ev(t + 61, 1, K_REP);
        expect_ev(t + 65, 1, K_REL);
        wait_until(t + 3);
        btn[1] = 1'b1;
        wait_until(t + 52);
        btn[0] = 1'b0;
        wait_until(t + 55);
        btn[1] = 1'b0;
        wait_until(t + 100);

        // Asynchronous reset while held, button stays high through it.
        t = cyc;
        btn[0] = 1'b1;
        expect_ev(t + 10, 0, K_PRESS);
        expect_ev(t + 42, 0, K_LONG);
        wait_until(t + 45);
        chk("level_before_reset", 64'(o_level[0]), 64'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("async_reset_outputs", {o_level, o_press, o_release, o_long, o_repeat}, 64'd0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        u = cyc;
        expect_ev(u + 10, 0, K_PRESS);
        expect_ev(u + 42, 0, K_LONG);
        expect_ev(u + 50, 0, K_REP);
        wait_until(u + 45);
        btn[0] = 1'b0;
        expect_ev(u + 55, 0, K_REL);
        wait_until(u + 90);

        chk("scoreboard_drained", 64'(sb.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/btn_conditioner.md
# btn_conditioner

Multi-channel button front end for the Basys3 lighting controller. Each channel synchronises a raw push-button, debounces it with a parametrised stability window, and emits one-cycle press and release pulses. It also emits a long-press pulse and optional auto-repeat pulses while the button is held. Its outputs feed the mode/brightness control logic directly, so no downstream edge detection is needed.

## Interface
- `N_CH`, 5, number of independent button channels (Basys3: U/D/L/R/C)
- `DEBOUNCE_CYC`, 131072, cycles the synchronised input must differ from `o_level` before `o_level` follows it; ≥2
- `LONG_CYC`, 100000000, cycles from the press pulse to the long-press pulse (1 s at 100 MHz); ≥2
- `REPEAT_CYC`, 20000000, auto-repeat period after the long press; ≥2
- `REPEAT_EN`, 1, 1 enables auto-repeat, 0 means `o_repeat` is held at 0
- `i_clk` in 1: 100 MHz system clock; the block uses this single clock
- `i_rst` in 1: reset, asynchronous, active-high
- `i_btn` in N_CH: raw asynchronous button inputs
- `o_level` out N_CH: debounced level
- `o_press` out N_CH: one-cycle pulse on debounced 0→1
- `o_release` out N_CH: one-cycle pulse on debounced 1→0
- `o_long` out N_CH: one-cycle pulse, once per hold
- `o_repeat` out N_CH: one-cycle pulses during a held button after `o_long`

## Operation
- Channels are fully independent. There is no shared state between them.
- Synchroniser: two flops per channel, `sync0` then `sync1`.
- Debounce counter, width `$clog2(DEBOUNCE_CYC)`:
  - Cleared while `sync1 == o_level`; otherwise increments.
  - On the edge where it equals `DEBOUNCE_CYC-1` with `sync1 != o_level`: `o_level <= sync1`, counter cleared.
  - Any mismatch gap restarts the window from 0 (bounce rejection).
- `o_press` and `o_release` are registered on the same edge that changes `o_level`.
- Hold FSM per channel: states IDLE, PRESSED, HELD. Hold counter width is `$clog2(max(LONG_CYC,REPEAT_CYC))`.
  - IDLE: on the `o_press` edge → PRESSED, counter cleared.
  - PRESSED: counter increments. On the edge where counter == `LONG_CYC-1`: `o_long` pulses, → HELD, counter cleared.
  - HELD: counter increments. On counter == `REPEAT_CYC-1`: `o_repeat` pulses (if `REPEAT_EN`), counter cleared, stay in HELD.
  - Debounced release in any state → IDLE, counter cleared.
- Release priority: if `o_level` falls on the same edge the counter hits its terminal value, only `o_release` pulses; `o_long` and `o_repeat` are suppressed.
- At most one of `o_press`, `o_release`, `o_long`, `o_repeat` is high per channel per cycle.

## Timing
- Reset: `sync0`, `sync1`, counters, `o_level`, and all pulse outputs are 0; FSMs go to IDLE. Reset takes effect immediately and asynchronously, including mid-debounce or mid-hold.
- Input held high through reset is treated as a new press: `o_press` fires after the full debounce latency following `i_rst` deassertion.
- Debounce latency: count the first edge that samples the new stable `i_btn` value as edge 1. `o_level` and the press/release pulse update on edge `DEBOUNCE_CYC+2`.
- `o_long` rises exactly `LONG_CYC` cycles after the cycle in which `o_press` is high.
- First `o_repeat` rises `REPEAT_CYC` cycles after `o_long`, then every `REPEAT_CYC` cycles.
- Counters never wrap: terminal compare clears them.

## Structure
- Shared package `btn_pkg`: FSM state encodings (`ST_IDLE`, `ST_PRESSED`, `ST_HELD`, 2 bits) and a `clog2`-style width helper.
- Sub-module `btn_channel`: one synchroniser, debouncer, and FSM per channel. The top level instantiates `N_CH` copies via generate and concatenates the outputs.

## Test plan
All scenarios use `DEBOUNCE_CYC=8`, `LONG_CYC=32`, `REPEAT_CYC=8`, `N_CH=2`.
- Clean press: ch0 0→1, first sampled at edge 1 → `o_level[0]`=1 and `o_press[0]` high for exactly one cycle at edge 10; ch1 stays 0.
- Bounce: ch0 toggles every 3 cycles for 30 cycles, then stays 1 → exactly one `o_press`, no `o_release`, `o_level` rises 10 edges after the final toggle.
- Hold 80 cycles past press → `o_long` at press+32; `o_repeat` at press+40, +48, +56, …. After release, one `o_release` and no further pulses. With `REPEAT_EN=0`, `o_repeat` is never asserted.
- Release whose debounced edge coincides with press+32 → `o_release` only, no `o_long`, FSM back in IDLE.
- Both channels pressed 3 cycles apart → independent `o_press` pulses 3 cycles apart; each channel's long-press timing is correct.
- Assert `i_rst` mid-HOLD with ch0 held → all outputs 0 within the reset cycle. After deassertion, `o_press[0]` fires at debounce latency and a fresh `o_long` fires 32 cycles later.
